// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with start-of-frame alignment.
// Collects WIDTH bits MSB-first from sin (qualified by sin_en), aligns each
// frame on sof, and presents completed words on a valid/ready output register.
// A completed word that cannot be stored (dout held, no consume) is dropped
// and raises the sticky overrun flag.
//
// Optional feature macro: SIPO_PARITY_EN
//   Adds a trailing even-parity bit per word and the parity_err output.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   sin          in   serial data bit
//   sin_en       in   sin qualifier; one bit consumed per enabled edge
//   sof          in   start of frame (with sin_en): sin is bit 0 of a word
//   dout         out  completed word, first received bit in the MSB
//   dout_valid   out  dout holds an unconsumed word
//   dout_ready   in   consumer accepts dout when dout_valid is high
//   overrun      out  sticky: a completed word was dropped
//   overrun_clr  in   synchronous clear of overrun (a same-edge set wins)
//   parity_err   out  (SIPO_PARITY_EN only) parity status of current dout
module sipo_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             overrun_clr
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
    // Whole word must be held while the parity bit arrives.
    localparam int unsigned SHW = WIDTH;
`else
    // Last data bit is taken straight from sin, so WIDTH-1 bits suffice.
    localparam int unsigned SHW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef SIPO_PARITY_EN
        ,
        PAR   = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SHW-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             complete_c;
    logic [WIDTH-1:0] word_c;
`ifdef SIPO_PARITY_EN
    logic             parity_err_q, parity_err_d;
    logic             par_bad_c;
`endif

    // Next-state: frame alignment, bit collection, word delivery, overrun.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        complete_c   = 1'b0;
        word_c       = '0;
`ifdef SIPO_PARITY_EN
        parity_err_d = parity_err_q;
        par_bad_c    = 1'b0;
`endif

        if (sin_en) begin
            if (sof) begin
                // Start (or resync) a frame; any partial word is discarded.
                state_d   = SHIFT;
                shreg_d   = SHW'(sin);
                bit_cnt_d = CW'(1);
            end else begin
                case (state_q)
                    SHIFT: begin
                        shreg_d = SHW'({shreg_q, sin});
                        if (bit_cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                            state_d   = PAR;
                            bit_cnt_d = CW'(WIDTH);
`else
                            complete_c = 1'b1;
                            word_c     = {shreg_q, sin};
                            bit_cnt_d  = '0;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PAR: begin
                        complete_c = 1'b1;
                        word_c     = shreg_q;
                        par_bad_c  = (^shreg_q) ^ sin;
                        state_d    = SHIFT;
                        bit_cnt_d  = '0;
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (complete_c) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word_c;
                dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err_d = par_bad_c;
`endif
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        // Clear first so that a same-edge drop still leaves the flag set.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (complete_c && dout_valid_q && !dout_ready) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed and randomized checks of sipo_deser against a
// bit-list reference model (frames kept as a queue of received bits).
module tb_sipo_deser;

    localparam int unsigned W = 4;
`ifdef SIPO_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    logic         clk;
    logic         rst;
    logic         sin;
    logic         sin_en;
    logic         sof;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         overrun_clr;
`ifdef SIPO_PARITY_EN
    logic         parity_err;
`endif

    sipo_deser #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin         (sin),
        .sin_en      (sin_en),
        .sof         (sof),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit           m_synced;
    bit           m_bits[$];
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovr;
    logic         m_perr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"},       32'(dout),       32'(m_dout));
        check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
        check({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
`ifdef SIPO_PARITY_EN
        check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
    endtask

    task automatic model_reset();
        m_synced = 1'b0;
        m_bits.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock edge of the model: bits accumulate in a list; a full list
    // becomes a word (first bit weighted highest) and is offered to the output.
    task automatic model_edge(input logic s, input logic en, input logic f,
                              input logic rdy, input logic clr);
        bit done = 1'b0;
        bit drop = 1'b0;
        int acc  = 0;
        int ones = 0;
        if (en) begin
            if (f) begin
                m_bits.delete();
                m_bits.push_back(s);
                m_synced = 1'b1;
            end else if (m_synced) begin
                m_bits.push_back(s);
                if (m_bits.size() == NB) begin
                    for (int i = 0; i < int'(W); i++) begin
                        acc  += int'(m_bits[i]) * (1 << (int'(W) - 1 - i));
                        ones += int'(m_bits[i]);
                    end
                    if (NB > W) ones += int'(m_bits[W]);
                    done = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_dout  = W'(acc);
                m_valid = 1'b1;
                m_perr  = (ones % 2) != 0;
            end else begin
                drop = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (clr)  m_ovr = 1'b0;
        if (drop) m_ovr = 1'b1;
    endtask

    // Drive inputs, take one edge, update model, compare 1 time unit later.
    task automatic cyc(input logic s, input logic en, input logic f,
                       input logic rdy, input logic clr);
        sin = s; sin_en = en; sof = f; dout_ready = rdy; overrun_clr = clr;
        @(posedge clk);
        model_edge(s, en, f, rdy, clr);
        #1;
        check_model("cyc");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_model("reset");
        check("reset.dout_zero", 32'(dout), 32'd0);
        rst = 1'b0;
    endtask

    // Send one word MSB-first (plus even parity bit when enabled).
    task automatic send_word(input logic [W-1:0] w, input bit use_sof, input logic rdy);
        for (int i = 0; i < int'(W); i++)
            cyc(w[W-1-i], 1'b1, use_sof && (i == 0), rdy, 1'b0);
`ifdef SIPO_PARITY_EN
        cyc(^w, 1'b1, 1'b0, rdy, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; sof = 1'b0;
        dout_ready = 1'b0; overrun_clr = 1'b0;
        model_reset();
        #12;
        do_reset();

        // 1: reset mid-word, then a clean word.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_word(4'b1011, 1'b1, 1'b0);
        check("t1.dout", 32'(dout), 32'hB);
        check("t1.valid", 32'(dout_valid), 32'd1);

        // 2: unsynchronised bits ignored, then an aligned word.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'(i % 2), 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2.valid_low", 32'(dout_valid), 32'd0);
        send_word(4'b0110, 1'b1, 1'b0);
        check("t2.dout", 32'(dout), 32'h6);

        // 3: continuous stream, consumer always ready.
        send_word(4'b1010, 1'b1, 1'b1);
        check("t3.dout0", 32'(dout), 32'hA);
        send_word(4'b0011, 1'b0, 1'b1);
        check("t3.dout1", 32'(dout), 32'h3);
        check("t3.ovr", 32'(overrun), 32'd0);

        // 4: backpressure and overrun.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'b1100, 1'b1, 1'b0);
        send_word(4'b0101, 1'b0, 1'b0);
        check("t4.dout_held", 32'(dout), 32'hC);
        check("t4.ovr_set", 32'(overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t4.ovr_clr", 32'(overrun), 32'd0);
        check("t4.dout_before_drain", 32'(dout), 32'hC);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4.drained", 32'(dout_valid), 32'd0);

        // 5: resync mid-word, then a word with a 3-cycle gap.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(4'b1001, 1'b1, 1'b0);
        check("t5.resync", 32'(dout), 32'h9);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5.gap_valid", 32'(dout_valid), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        check("t5.gap_dout", 32'(dout), 32'h6);
        check("t5.gap_valid1", 32'(dout_valid), 32'd1);

`ifdef SIPO_PARITY_EN
        // 6: good then bad parity.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6.good_perr", 32'(parity_err), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t6.bad_dout", 32'(dout), 32'h7);
        check("t6.bad_perr", 32'(parity_err), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 19) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-to-parallel deserializer that sits directly downstream of the `piso` shifter. It samples the serial bit stream on `sin` and reassembles `WIDTH`-bit words, aligning to a start-of-frame strobe. It presents each completed word on a valid/ready output register and flags overruns when the consumer stalls.

## Interface
- `WIDTH`, default 4: word width in bits; minimum 2.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sin`  in  1  serial data bit, sampled only when `sin_en`=1.
- `sin_en`  in  1  bit-valid qualifier; one bit is consumed per `clk` edge with `sin_en`=1.
- `sof`  in  1  start of frame; meaningful only when `sin_en`=1; marks `sin` as the first bit of a word.
- `dout`  out  WIDTH  completed word; the first received bit is at `dout[WIDTH-1]` (MSB-first).
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` on an edge where `dout_valid`=1 and `dout_ready`=1.
- `overrun`  out  1  sticky: a completed word was dropped.
- `overrun_clr`  in  1  synchronous clear of `overrun`.
- `parity_err`  out  1  present only with `PARITY_EN`; qualifies the current `dout`.

## Operation
- **States:**
  - `IDLE`: from reset; ignores `sin` until `sof`=1 and `sin_en`=1.
  - `SHIFT`: collecting data bits.
  - `PAR`: `PARITY_EN` only; collecting the parity bit.
- **Transitions:**
  - `IDLE`→`SHIFT` on `sof`&`sin_en`. That bit is stored as bit 0 and `bit_cnt` becomes 1.
  - In `SHIFT`, each `sin_en` edge shifts `sin` in and increments `bit_cnt`.
  - On the edge that samples bit `WIDTH-1`, one of two things happens:
    - Without `PARITY_EN`: the word completes, `bit_cnt` wraps to 0, and the state stays `SHIFT`. Back-to-back words need no further `sof`.
    - With `PARITY_EN`: the state goes to `PAR`. The next `sin_en` bit is even parity over the word; the word then completes and the state returns to `SHIFT` with `bit_cnt`=0.
- **Resync:** `sof`&`sin_en` in `SHIFT` or `PAR` aborts the partial word with no output and no flag. That bit becomes bit 0 of a new word, with `bit_cnt`=1 and state `SHIFT`.
- **Word completion:**
  - If `dout_valid`=0, or `dout_ready`=1 on the same edge: load `dout`, set `dout_valid`=1.
  - Otherwise drop the word, leave `dout` unchanged and set `overrun`=1.
- **Handshake:**
  - An edge with `dout_valid`&`dout_ready` and no completing word clears `dout_valid`.
  - A consume and a completion on the same edge load the new word; `dout_valid` stays 1 and no overrun occurs.
- **overrun:**
  - Cleared only by `rst` or `overrun_clr`.
  - If a set and `overrun_clr` occur on the same edge, the set wins.
- **Bit counter:** `bit_cnt` width is $clog2(WIDTH+1). It never exceeds `WIDTH-1` in `SHIFT`.

## Timing
- **Reset values:** `dout`=0, `dout_valid`=0, `overrun`=0, `parity_err`=0, state `IDLE`, `bit_cnt`=0, shift register 0. Reset mid-word discards the partial word.
- **Latency:** `dout` and `dout_valid` update on the same edge that samples the last data bit (or the parity bit with `PARITY_EN`). They are visible in the following cycle.
- **Throughput:** one word per `WIDTH` `sin_en` cycles, or `WIDTH+1` with `PARITY_EN`. `sin_en` may be held high continuously.
- **Gaps:** `sin_en`=0 cycles hold all state. The partial word persists indefinitely.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`SIPO_PARITY_EN` defined:**
  - Adds the `PAR` state and the `parity_err` port.
  - `parity_err` loads with `dout`: 1 if XOR(word, parity bit)≠0.
  - A bad-parity word is still delivered.
  - `parity_err` holds until the next word load or reset.
- **Not defined:** no `PAR` state and no `parity_err` port. Words are pure `WIDTH` bits.

## Test plan
1. **Reset:** `rst`=1 mid-stream after 2 bits of a word, then release and send `sof`+bits 1,0,1,1 → all outputs 0 after reset; then `dout`=4'b1011, `dout_valid`=1 one cycle after the 4th sampling edge.
2. **Pre-sync input:** bits with `sin_en`=1 but no `sof` after reset → `dout_valid` stays 0. Then `sof` with 0110 → `dout`=4'b0110.
3. **Continuous stream:** `sin_en` held 1, `dout_ready` held 1, stream 1010 0011 after one `sof` → `dout`=4'b1010 then 4'b0011, four cycles apart, no `overrun`.
4. **Backpressure:** `dout_ready`=0 over two complete words 1100, 0101 → `dout` stays 4'b1100, `overrun`=1. Then `overrun_clr`=1 → `overrun`=0, and `dout_ready`=1 drains 1100.
5. **Resync and gaps:** `sof` after 2 bits of a word → partial discarded, new word 1001 delivered. Mid-word `sin_en`=0 for 3 cycles → same word, completion delayed by 3 cycles.
6. **Parity (`SIPO_PARITY_EN`):** 0111 with parity bit 1 → `parity_err`=0. 0111 with parity bit 0 → `dout`=4'b0111, `parity_err`=1.
